// File: rtl/jtdd2_snd_pkg.sv
// jtdd2_snd_pkg: shared types and constants for the DD2 sound ROM arbiter.
package jtdd2_snd_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, WAIT} st_e;
  localparam logic CH_CPU   = 1'b0;
  localparam logic CH_ADPCM = 1'b1;
  localparam logic [21:0] ROM0_OFFSET_DEF = 22'h00000;
  localparam logic [21:0] ROM1_OFFSET_DEF = 22'h08000;
endpackage

// File: rtl/jtdd2_romarb_slot.sv
// jtdd2_romarb_slot: one-entry data/tag buffer for a single ROM requester.
module jtdd2_romarb_slot #(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          load,
  input  logic [AW-1:0] tag_in,
  input  logic [7:0]    din,
  output logic [7:0]    data,
  output logic          ok,
  output logic          pend
);
  logic          v_q, v_d;
  logic [AW-1:0] a_q, a_d;
  logic [7:0]    d_q, d_d;
  logic          hit;
  always_comb begin
    v_d = flush ? 1'b0 : (load ? 1'b1 : v_q);
    a_d = load ? tag_in : a_q;
    d_d = load ? din : d_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      a_q <= '0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      a_q <= a_d;
      d_q <= d_d;
    end
  end
  assign hit  = v_q & (addr == a_q);
  assign ok   = cs & hit;
  assign pend = cs & ~hit;
  assign data = d_q;
endmodule

// File: rtl/jtdd2_snd_romarb.sv
// jtdd2_snd_romarb: round-robin sharing of one SDRAM read port by the sound CPU and ADPCM ROMs.
// Define JTDD2_ROMARB_STATS_EN to add per-channel saturating miss counters (st_sel/st_dout).
module jtdd2_snd_romarb
  import jtdd2_snd_pkg::*;
#(
  parameter int AW0   = 15,
  parameter int AW1   = 18,
  parameter int OUTAW = 22,
  parameter logic [OUTAW-1:0] ROM0_OFFSET = OUTAW'(ROM0_OFFSET_DEF),
  parameter logic [OUTAW-1:0] ROM1_OFFSET = OUTAW'(ROM1_OFFSET_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             downloading,
  input  logic             rom0_cs,
  input  logic [AW0-1:0]   rom0_addr,
  output logic [7:0]       rom0_data,
  output logic             rom0_ok,
  input  logic             rom1_cs,
  input  logic [AW1-1:0]   rom1_addr,
  output logic [7:0]       rom1_data,
  output logic             rom1_ok,
  output logic             mem_cs,
  output logic [OUTAW-1:0] mem_addr,
  input  logic [7:0]       mem_data,
`ifdef JTDD2_ROMARB_STATS_EN
  input  logic             mem_ok,
  input  logic             st_sel,
  output logic [15:0]      st_dout
`else
  input  logic             mem_ok
`endif
);
  localparam int LW = AW0 > AW1 ? AW0 : AW1;
  st_e              st_q, st_d;
  logic             mem_cs_q, mem_cs_d;
  logic [OUTAW-1:0] mem_addr_q, mem_addr_d;
  logic [LW-1:0]    lat_q, lat_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic             pend0, pend1, pick, load;
  assign pick = (pend0 & pend1) ? ~last_q : pend1;
  assign load = ~downloading & (st_q == WAIT) & mem_ok;
  always_comb begin
    st_d       = st_q;
    mem_cs_d   = mem_cs_q;
    mem_addr_d = mem_addr_q;
    lat_d      = lat_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    if (downloading) begin
      st_d     = IDLE;
      mem_cs_d = 1'b0;
    end else begin
      case (st_q)
        IDLE: if (pend0 | pend1) begin
          st_d       = SETTLE;
          mem_cs_d   = 1'b1;
          gnt_d      = pick;
          last_d     = pick;
          mem_addr_d = (pick == CH_ADPCM) ? ROM1_OFFSET + OUTAW'(rom1_addr)
                                          : ROM0_OFFSET + OUTAW'(rom0_addr);
          lat_d      = (pick == CH_ADPCM) ? LW'(rom1_addr) : LW'(rom0_addr);
        end
        SETTLE: st_d = WAIT;
        WAIT: if (mem_ok) begin
          st_d     = IDLE;
          mem_cs_d = 1'b0;
        end
        default: st_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= IDLE;
      mem_cs_q   <= 1'b0;
      mem_addr_q <= '0;
      lat_q      <= '0;
      gnt_q      <= CH_CPU;
      last_q     <= CH_ADPCM;
    end else begin
      st_q       <= st_d;
      mem_cs_q   <= mem_cs_d;
      mem_addr_q <= mem_addr_d;
      lat_q      <= lat_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
    end
  end
  assign mem_cs   = mem_cs_q;
  assign mem_addr = mem_addr_q;
  jtdd2_romarb_slot #(.AW(AW0)) u_slot0 (
    .clk(clk), .rst_n(rst_n), .flush(downloading),
    .cs(rom0_cs), .addr(rom0_addr),
    .load(load & (gnt_q == CH_CPU)), .tag_in(lat_q[AW0-1:0]), .din(mem_data),
    .data(rom0_data), .ok(rom0_ok), .pend(pend0)
  );
  jtdd2_romarb_slot #(.AW(AW1)) u_slot1 (
    .clk(clk), .rst_n(rst_n), .flush(downloading),
    .cs(rom1_cs), .addr(rom1_addr),
    .load(load & (gnt_q == CH_ADPCM)), .tag_in(lat_q[AW1-1:0]), .din(mem_data),
    .data(rom1_data), .ok(rom1_ok), .pend(pend1)
  );
`ifdef JTDD2_ROMARB_STATS_EN
  logic        grant;
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  assign grant = ~downloading & (st_q == IDLE) & (pend0 | pend1);
  always_comb begin
    cnt0_d = (grant & (pick == CH_CPU)   & ~&cnt0_q) ? cnt0_q + 16'd1 : cnt0_q;
    cnt1_d = (grant & (pick == CH_ADPCM) & ~&cnt1_q) ? cnt1_q + 16'd1 : cnt1_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end
  assign st_dout = st_sel ? cnt1_q : cnt0_q;
`endif
endmodule

// File: tb/tb_jtdd2_snd_romarb.sv
// tb_jtdd2_snd_romarb: directed plus randomized checks against a transaction-level model of the arbiter.
module tb_jtdd2_snd_romarb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic        rom0_cs = 1'b0;
  logic [14:0] rom0_addr = '0;
  logic [7:0]  rom0_data;
  logic        rom0_ok;
  logic        rom1_cs = 1'b0;
  logic [17:0] rom1_addr = '0;
  logic [7:0]  rom1_data;
  logic        rom1_ok;
  logic        mem_cs;
  logic [21:0] mem_addr;
  logic [7:0]  mem_data = '0;
  logic        mem_ok = 1'b0;

  jtdd2_snd_romarb dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .rom0_cs(rom0_cs), .rom0_addr(rom0_addr), .rom0_data(rom0_data), .rom0_ok(rom0_ok),
    .rom1_cs(rom1_cs), .rom1_addr(rom1_addr), .rom1_data(rom1_data), .rom1_ok(rom1_ok),
    .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ok(mem_ok)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: each channel owns a cached (valid, tag, data) entry; at most one
  // fetch is outstanding, tracked by its age in cycles since the grant.
  logic        m_v[2];
  logic [17:0] m_tag[2];
  logic [7:0]  m_dat[2];
  logic        m_busy;
  int          m_age, m_ch, m_last;
  logic [17:0] m_fa;
  logic        m_cs;
  logic [21:0] m_ma;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 1'b0; m_tag[i] = '0; m_dat[i] = '0;
    end
    m_busy = 1'b0; m_age = 0; m_ch = 0; m_last = 1; m_fa = '0;
    m_cs = 1'b0; m_ma = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; downloading = 1'b0; rom0_cs = 1'b0; rom1_cs = 1'b0; mem_ok = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_ok0", rom0_ok, 0);
    chk("rst_ok1", rom1_ok, 0);
    chk("rst_d0", rom0_data, 0);
    chk("rst_d1", rom1_data, 0);
    chk("rst_cs", mem_cs, 0);
    chk("rst_addr", mem_addr, 0);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic dl, input logic c0, input logic [14:0] a0,
                      input logic c1, input logic [17:0] a1,
                      input logic mok, input logic [7:0] md);
    logic [17:0] ad[2];
    logic        cs[2], hit[2];
    downloading = dl; rom0_cs = c0; rom0_addr = a0; rom1_cs = c1; rom1_addr = a1;
    mem_ok = mok; mem_data = md;
    ad[0] = 18'(a0); ad[1] = a1; cs[0] = c0; cs[1] = c1;
    for (int i = 0; i < 2; i++) hit[i] = m_v[i] && (m_tag[i] == ad[i]);
    #1;
    chk("ok0", rom0_ok, cs[0] && hit[0]);
    chk("ok1", rom1_ok, cs[1] && hit[1]);
    chk("data0", rom0_data, m_dat[0]);
    chk("data1", rom1_data, m_dat[1]);
    chk("mem_cs", mem_cs, m_cs);
    if (m_cs) chk("mem_addr", mem_addr, m_ma);
    if (dl) begin
      m_busy = 1'b0; m_cs = 1'b0; m_v[0] = 1'b0; m_v[1] = 1'b0;
    end else if (m_busy) begin
      if (m_age >= 1 && mok) begin
        m_v[m_ch] = 1'b1; m_tag[m_ch] = m_fa; m_dat[m_ch] = md;
        m_busy = 1'b0; m_cs = 1'b0;
      end else m_age++;
    end else if ((cs[0] && !hit[0]) || (cs[1] && !hit[1])) begin
      if (cs[0] && !hit[0] && cs[1] && !hit[1]) m_ch = 1 - m_last;
      else m_ch = (cs[1] && !hit[1]) ? 1 : 0;
      m_last = m_ch; m_busy = 1'b1; m_age = 0; m_fa = ad[m_ch]; m_cs = 1'b1;
      m_ma = (m_ch == 1) ? 22'h08000 + 22'(ad[1]) : 22'(ad[0]);
    end
    @(negedge clk);
  endtask

  logic        r_c0, r_c1, r_dl;
  logic [14:0] r_a0;
  logic [17:0] r_a1;

  initial begin
    @(negedge clk);
    do_reset();
    // Plain miss: mem_ok held high from SETTLE on, so the SETTLE one must be ignored.
    step(0, 1, 15'h0123, 0, 18'h0, 0, 8'h00);
    chk("plan_addr", mem_addr, 22'h00123);
    step(0, 1, 15'h0123, 0, 18'h0, 1, 8'hEE);
    step(0, 1, 15'h0123, 0, 18'h0, 1, 8'h5A);
    chk("plan_ok0", rom0_ok, 1);
    chk("plan_d0", rom0_data, 8'h5A);
    for (int i = 0; i < 10; i++) step(0, 0, 15'h0123, 0, 18'h0, 0, 8'h00);
    step(0, 1, 15'h0123, 0, 18'h0, 0, 8'h00);
    chk("hit_nocs", mem_cs, 0);
    // Tie after reset, then continuous misses alternate.
    do_reset();
    step(0, 1, 15'h0200, 1, 18'h00010, 0, 8'h00);
    chk("tie_addr", mem_addr, 22'h00200);
    for (int i = 0; i < 3; i++) step(0, 1, 15'h0200, 1, 18'h00010, 1, 8'h11);
    chk("tie_addr1", mem_addr, 22'h08010);
    // Address change mid-WAIT on channel 1.
    step(0, 1, 15'h0200, 1, 18'h00011, 0, 8'h00);
    step(0, 1, 15'h0200, 1, 18'h00011, 1, 8'h22);
    for (int i = 0; i < 4; i++) step(0, 1, 15'h0200, 1, 18'h00011, 1, 8'h33);
    chk("chg_ok1", rom1_ok, 1);
    // Download pulse during WAIT, then a stale mem_ok.
    step(0, 1, 15'h0300, 1, 18'h00011, 0, 8'h00);
    step(0, 1, 15'h0300, 1, 18'h00011, 0, 8'h00);
    step(1, 1, 15'h0300, 1, 18'h00011, 0, 8'h00);
    chk("dl_cs", mem_cs, 0);
    chk("dl_ok1", rom1_ok, 0);
    step(0, 1, 15'h0300, 1, 18'h00011, 1, 8'h44);
    for (int i = 0; i < 8; i++) step(0, 1, 15'h0300, 1, 18'h00011, 1, 8'h55);
    // Randomized traffic over small address pools so hits and ties are common.
    r_c0 = 0; r_c1 = 0; r_a0 = 0; r_a1 = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) r_c0 = ~r_c0;
      if ($urandom_range(0, 9) == 0) r_c1 = ~r_c1;
      if ($urandom_range(0, 7) == 0)
        r_a0 = ($urandom_range(0, 15) == 0) ? 15'($urandom) : 15'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)
        r_a1 = ($urandom_range(0, 15) == 0) ? 18'($urandom) : 18'($urandom_range(16, 19));
      r_dl = ($urandom_range(0, 149) == 0);
      step(r_dl, r_c0, r_a0, r_c1, r_a1, 1'($urandom_range(0, 1)), 8'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
